// File: rtl/cop_sequencer.sv
// GCD/LCM coprocessor sequencer: latches a command word from the core,
// stalls the core while iterating, then returns the result with a done pulse.
module cop_sequencer #(
  parameter int W  = 8,
  parameter int CW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     cmd,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [2*W-1:0]  result,
  output logic [CW-1:0]   iters
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q;
  logic [2*W-1:0] x_q;
  logic [2*W-1:0] y_q;
  logic [W-1:0]   ra_q;
  logic [W-1:0]   rb_q;
  logic           op_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] result_q;
  logic [CW-1:0]  iters_q;

  logic [W-1:0]   a_w;
  logic [W-1:0]   b_w;
  logic [2*W-1:0] ra_ext;
  logic [2*W-1:0] rb_ext;
  logic           unused_cmd;

  assign a_w        = cmd[W-1:0];
  assign b_w        = cmd[8 +: W];
  assign ra_ext     = {{W{1'b0}}, ra_q};
  assign rb_ext     = {{W{1'b0}}, rb_q};
  assign unused_cmd = ^cmd[31:17];

  // The step counter runs privately so iters only moves on DONE entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      iters_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ra_q  <= a_w;
            rb_q  <= b_w;
            op_q  <= cmd[16];
            x_q   <= {{W{1'b0}}, a_w};
            y_q   <= {{W{1'b0}}, b_w};
            cnt_q <= '0;
            if (a_w == '0 || b_w == '0) begin
              result_q <= cmd[16] ? '0
                        : {{W{1'b0}}, a_w | b_w};
              iters_q  <= '0;
              state_q  <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (x_q == y_q) begin
            result_q <= x_q;
            iters_q  <= cnt_q;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (!op_q) begin
              if (x_q > y_q) x_q <= x_q - y_q;
              else           y_q <= y_q - x_q;
            end else begin
              if (x_q < y_q) x_q <= x_q + ra_ext;
              else           y_q <= y_q + rb_ext;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q == RUN) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign stall  = (start && state_q == IDLE) || busy;
  assign result = result_q;
  assign iters  = iters_q;

endmodule

// File: tb/tb_cop_sequencer.sv
// Randomized self-checking bench for cop_sequencer against a
// Euclid-based GCD/LCM reference model.
module tb_cop_sequencer;

  localparam int W  = 8;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     cmd = '0;
  logic            busy;
  logic            stall;
  logic            done;
  logic [2*W-1:0]  result;
  logic [CW-1:0]   iters;

  int checks = 0;
  int errors = 0;

  cop_sequencer #(.W(W), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cmd    (cmd),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result),
    .iters  (iters)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Subtractive GCD steps = sum of Euclid quotients - 1;
  // LCM steps = L/A + L/B - 2.
  function automatic void model(input bit op, input int a,
                                input int b, output int res,
                                output int it, output int cyc);
    int p, q, r, sq;
    if (a == 0 || b == 0) begin
      res = op ? 0 : (a | b);
      it  = 0;
      cyc = 1;
      return;
    end
    p  = (a > b) ? a : b;
    q  = (a > b) ? b : a;
    sq = 0;
    while (q != 0) begin
      sq += p / q;
      r  = p % q;
      p  = q;
      q  = r;
    end
    if (!op) begin
      res = p;
      it  = sq - 1;
    end else begin
      res = (a / p) * b;
      it  = res / a + res / b - 2;
    end
    cyc = it + 2;
  endfunction

  task automatic run_op(input string tag, input bit op,
                        input int a, input int b,
                        input bit noise);
    int er, ei, ec, cyc;
    model(op, a, b, er, ei, ec);
    cmd       = $urandom;
    cmd[16]   = op;
    cmd[15:8] = b[7:0];
    cmd[7:0]  = a[7:0];
    start     = 1'b1;
    #1;
    chk({tag, ":stall_req"}, 32'(stall), 1);
    chk({tag, ":idle_busy"}, 32'(busy), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    cmd   = $urandom;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 700) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        cmd   = $urandom;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, ":done_cyc"}, cyc, ec);
    chk({tag, ":result"}, 32'(result), er);
    chk({tag, ":iters"}, 32'(iters), ei);
    chk({tag, ":busy_d"}, 32'(busy), 1);
    chk({tag, ":stall_d"}, 32'(stall), 1);
    @(posedge clk);
    #1;
    chk({tag, ":done_1cy"}, 32'(done), 0);
    chk({tag, ":busy_off"}, 32'(busy), 0);
    chk({tag, ":stall_off"}, 32'(stall), 0);
    chk({tag, ":res_hold"}, 32'(result), er);
    chk({tag, ":it_hold"}, 32'(iters), ei);
  endtask

  initial begin
    int a, b;
    bit op;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_iters", 32'(iters), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("gcd12_18", 1'b0, 12, 18, 1'b0);
    run_op("lcm4_6", 1'b1, 4, 6, 1'b0);
    run_op("lcm255_254", 1'b1, 255, 254, 1'b0);
    run_op("gcd0_7", 1'b0, 0, 7, 1'b0);
    run_op("lcm0_7", 1'b1, 0, 7, 1'b0);
    run_op("gcd0_0", 1'b0, 0, 0, 1'b0);
    run_op("gcd255_1", 1'b0, 255, 1, 1'b1);
    run_op("after_busy", 1'b1, 3, 5, 1'b0);

    // Abort an LCM run with reset.
    cmd   = 32'h0001_C7C8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_stall", 32'(stall), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_iters", 32'(iters), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_idle", 32'(busy), 0);
    run_op("gcd9_9", 1'b0, 9, 9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? 0
         : int'($urandom_range(1, 255));
      b  = ($urandom_range(0, 9) == 0) ? 0
         : int'($urandom_range(1, 255));
      op = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), op, a, b,
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cop_sequencer.md
Name: cop_sequencer

Overview:
- Sequencer for the GCD/LCM coprocessor attached to the single-cycle RISC-V core.
- Latches the 32-bit command word that the core drives on WDFinal when Start is high. Bit 16 is the op select, bits 15:8 are operand B, bits 7:0 are operand A.
- Runs an iterative subtract/accumulate algorithm, one step per cycle.
- Raises stall to freeze the core while it runs, then returns a 2W-bit result with a one-cycle done pulse.

Parameters:
- W, 8, operand width in bits. The result width is 2W.
- CW, 10, width of the iteration counter. It must hold at least 2^(W+1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset. Asserting it low clears all state immediately; release is synchronous to clk.
- start  input  1  command strobe from the core; sampled only in IDLE
- cmd  input  32  command word: [16]=op (0=GCD, 1=LCM), [15:8]=B, [7:0]=A; [31:17] ignored
- busy  output  1  high in RUN and DONE
- stall  output  1  equals (start & IDLE) | busy; holds the core PC
- done  output  1  one-cycle pulse when the result is valid
- result  output  2W  final GCD/LCM value; held until the next accepted start
- iters  output  CW  number of step cycles used by the last operation; held like result

Behaviour:
- Reset values: state=IDLE, busy=0, stall=0, done=0, result=0, iters=0, internal x/y/ra/rb=0.
- States are IDLE, RUN and DONE.
- IDLE, start=1 at a clock edge: latch ra=A, rb=B, op, x=A, y=B (zero-extended to 2W), iters=0.
  - If A==0 or B==0: go directly to DONE. Result is GCD = A|B (so gcd(0,0)=0), or LCM = 0.
  - Otherwise go to RUN.
- IDLE, start=0: hold.
- RUN, each cycle, first compare x and y:
  - x==y: result<=x, go to DONE.
  - GCD step, x!=y: if x>y then x<=x-y, else y<=y-x; iters++.
  - LCM step, x!=y: if x<y then x<=x+ra, else y<=y+rb; iters++.
  - All arithmetic is unsigned at 2W bits. With nonzero W-bit operands, LCM never overflows 2W bits and GCD never underflows.
- DONE: done=1 for exactly one cycle; busy stays 1; next state is IDLE.
- Latency: accept edge → RUN → (iters step cycles) → equality cycle → DONE. With nonzero operands, done is high in cycle iters+2 after the accept edge. With a zero operand, done is high in the cycle right after the accept edge.
- start while busy (RUN or DONE): ignored and not queued. The core must hold Start until stall drops.
- result and iters change only when DONE is entered; they are stable in IDLE.
- Reset asserted mid-RUN: abort immediately, clear all outputs, return to IDLE. No done pulse is produced.
- cmd is sampled only at the accept edge; later changes on cmd have no effect.

Test Plan:
- Reset, then start with cmd=0x0000_120C (GCD, A=12, B=18) → stall/busy high; iters=2; result=6; one done pulse 4 cycles after accept; busy low the following cycle.
- cmd=0x0001_0604 (LCM, A=4, B=6) → iters=3, result=12, done 5 cycles after accept.
- cmd=0x0001_FEFF (LCM, 255, 254) → result=64770 with no overflow; iters=507, which equals 254+253.
- cmd=0x0000_0700 (GCD, A=0, B=7) → result=7, iters=0, done the cycle after accept. Then LCM(0,7) → result=0.
- During a GCD(255,1) run, pulse start with different cmd values → ignored; result=1, iters=254. After IDLE is re-entered, a new start is accepted normally.
- Drive reset low mid-run of LCM(200,199) → outputs are 0 immediately, no done pulse. After release, GCD(9,9) → result=9, iters=0.
